// File: rtl/cache_mem_ctrl.sv
// Purpose : memory-side controller behind the L1 data cache; refills read misses and writes every store through to memory.
// Latency : read miss stalls >= 3 cycles (detect, request+ack, fill); store stalls >= 1 cycle; each cycle without mem_ack_i adds one.
// Backpress: stall_o holds the CPU pipeline while memory has not acknowledged; mem_* stay frozen from request until mem_ack_i.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   cpu_req_i/cpu_wr_en_i/...     CPU access: valid, store flag, byte address, store data, byte enables
//   cache_hit_i                   cache hit flag for the current CPU address
//   stall_o                       combinational pipeline freeze
//   fill_en_o, fill_data_o        one-cycle refill pulse and the registered refill word
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o, mem_ack_i, mem_rdata_i   main-memory handshake
//   rd_miss_cnt_o, wr_cnt_o       saturating counts of serviced read misses and completed stores
module cache_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
    input  logic [3:0]            cpu_byte_en_i,
    input  logic                  cache_hit_i,
    output logic                  stall_o,
    output logic                  fill_en_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  rd_miss_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        FILL   = 2'd2,
        WR_REQ = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:2]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_data;
    logic [3:0]              lat_be;
    logic [DATA_WIDTH-1:0]   fill_data_q;
    logic [CNT_WIDTH-1:0]    rd_cnt_q;
    logic [CNT_WIDTH-1:0]    wr_cnt_q;
    logic                    start_rd;
    logic                    start_wr;
    logic [ADDR_WIDTH-1:0]   word_addr;

    // Memory is word addressed; the byte offset is carried only by the byte enables.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Stores always go to memory, hit or miss; loads only when they miss.
    assign start_rd  = (state == IDLE) && cpu_req_i && !cpu_wr_en_i && !cache_hit_i;
    assign start_wr  = (state == IDLE) && cpu_req_i && cpu_wr_en_i;
    assign word_addr = {lat_addr, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_be      <= '0;
            fill_data_q <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            state <= next_state;
            // Latched copies decouple memory from CPU inputs that may move during the stall.
            if (start_rd || start_wr) begin
                lat_addr <= cpu_addr_i[ADDR_WIDTH-1:2];
                lat_be   <= cpu_byte_en_i;
            end
            if (start_wr) begin
                lat_data <= cpu_wr_data_i;
            end
            if (state == RD_REQ && mem_ack_i) begin
                fill_data_q <= mem_rdata_i;
                if (rd_cnt_q != CNT_MAX) begin
                    rd_cnt_q <= rd_cnt_q + CNT_ONE;
                end
            end
            if (state == WR_REQ && mem_ack_i) begin
                if (wr_cnt_q != CNT_MAX) begin
                    wr_cnt_q <= wr_cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        next_state  = state;
        stall_o     = 1'b0;
        fill_en_o   = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        // Reset masks every output, including the combinational stall.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (start_rd) begin
                        stall_o    = 1'b1;
                        next_state = RD_REQ;
                    end else if (start_wr) begin
                        stall_o    = 1'b1;
                        next_state = WR_REQ;
                    end
                end
                RD_REQ: begin
                    stall_o    = 1'b1;
                    mem_req_o  = 1'b1;
                    mem_addr_o = word_addr;
                    mem_be_o   = 4'b1111;
                    if (mem_ack_i) begin
                        next_state = FILL;
                    end
                end
                FILL: begin
                    stall_o    = 1'b1;
                    fill_en_o  = 1'b1;
                    next_state = IDLE;
                end
                WR_REQ: begin
                    // The pipeline retires the store on the ack edge, so release the stall in that cycle.
                    stall_o     = !mem_ack_i;
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = word_addr;
                    mem_wdata_o = lat_data;
                    mem_be_o    = lat_be;
                    if (mem_ack_i) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign fill_data_o   = rst ? '0 : fill_data_q;
    assign rd_miss_cnt_o = rst ? '0 : rd_cnt_q;
    assign wr_cnt_o      = rst ? '0 : wr_cnt_q;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Purpose : self-checking bench for cache_mem_ctrl: per-cycle vector table plus reset-abort and counter-saturation sequences.
// Latency : inputs driven 1 time unit after the rising edge, outputs compared 2 units later.
// Backpress: memory acknowledge is driven directly from the vectors, including wait cycles and zero-wait acks.
module tb_cache_mem_ctrl;

    localparam bit O = 1'b0;
    localparam bit I = 1'b1;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wr_en, cache_hit, mem_ack;
    logic [31:0] cpu_addr, cpu_wr_data, mem_rdata;
    logic [3:0]  cpu_byte_en;

    logic        stall, fill_en, mem_req, mem_we;
    logic [31:0] fill_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [15:0] rd_cnt, wr_cnt;

    logic        s_stall, s_fill_en, s_mem_req, s_mem_we;
    logic [31:0] s_fill_data, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_be;
    logic [1:0]  s_rd_cnt, s_wr_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req), .cpu_wr_en_i(cpu_wr_en), .cpu_addr_i(cpu_addr),
        .cpu_wr_data_i(cpu_wr_data), .cpu_byte_en_i(cpu_byte_en), .cache_hit_i(cache_hit),
        .stall_o(stall), .fill_en_o(fill_en), .fill_data_o(fill_data),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .rd_miss_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
    );

    // Narrow-counter instance shares all inputs; only its counters are inspected.
    cache_mem_ctrl #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req), .cpu_wr_en_i(cpu_wr_en), .cpu_addr_i(cpu_addr),
        .cpu_wr_data_i(cpu_wr_data), .cpu_byte_en_i(cpu_byte_en), .cache_hit_i(cache_hit),
        .stall_o(s_stall), .fill_en_o(s_fill_en), .fill_data_o(s_fill_data),
        .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr),
        .mem_wdata_o(s_mem_wdata), .mem_be_o(s_mem_be), .mem_ack_i(mem_ack),
        .mem_rdata_i(mem_rdata), .rd_miss_cnt_o(s_rd_cnt), .wr_cnt_o(s_wr_cnt)
    );

    typedef struct {
        logic        rst, req, we, hit;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall, e_mreq, e_mwe, e_fill;
        logic [31:0] e_maddr, e_mwdata;
        logic [3:0]  e_mbe;
        logic [31:0] e_fdata;
        logic [15:0] e_rc, e_wc;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic q, input logic w, input logic h,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         input logic k, input logic [31:0] rd);
        rst = r; cpu_req = q; cpu_wr_en = w; cache_hit = h;
        cpu_addr = a; cpu_wr_data = d; cpu_byte_en = b;
        mem_ack = k; mem_rdata = rd;
    endtask

    task automatic apply(input int i);
        vec_t v;
        v = vt[i];
        drive(v.rst, v.req, v.we, v.hit, v.addr, v.wdata, v.be, v.ack, v.rdata);
        #2;
        chk($sformatf("v%0d stall", i),     32'(stall),     32'(v.e_stall));
        chk($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(v.e_mreq));
        chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(v.e_mwe));
        chk($sformatf("v%0d fill_en", i),   32'(fill_en),   32'(v.e_fill));
        chk($sformatf("v%0d mem_addr", i),  mem_addr,       v.e_maddr);
        chk($sformatf("v%0d mem_wdata", i), mem_wdata,      v.e_mwdata);
        chk($sformatf("v%0d mem_be", i),    32'(mem_be),    32'(v.e_mbe));
        chk($sformatf("v%0d fill_data", i), fill_data,      v.e_fdata);
        chk($sformatf("v%0d rd_cnt", i),    32'(rd_cnt),    32'(v.e_rc));
        chk($sformatf("v%0d wr_cnt", i),    32'(wr_cnt),    32'(v.e_wc));
        tick();
    endtask

    // Zero-wait read miss: detect, request with ack, fill; returns in IDLE.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] d);
        drive(O, I, O, O, a, Z, 4'hF, O, Z);
        tick();
        drive(O, O, O, O, Z, Z, 4'h0, I, d);
        tick();
        drive(O, O, O, O, Z, Z, 4'h0, O, Z);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        //        rst req we hit  addr          wdata         be       ack rdata          | stall mreq mwe fill maddr        mwdata        mbe      fdata         rc      wc
        vt[0]  = '{O, I, O, I, 32'h0000_0100, Z,            4'hF,    O, Z,             O, O, O, O, Z,            Z,            4'h0,    Z,            16'd0, 16'd0};
        vt[1]  = '{O, O, O, O, Z,             Z,            4'h0,    O, Z,             O, O, O, O, Z,            Z,            4'h0,    Z,            16'd0, 16'd0};
        vt[2]  = '{O, I, O, O, 32'h0000_1234, Z,            4'hF,    O, Z,             I, O, O, O, Z,            Z,            4'h0,    Z,            16'd0, 16'd0};
        vt[3]  = '{O, I, O, O, 32'h9999_0000, Z,            4'hF,    O, Z,             I, I, O, O, 32'h0000_1234, Z,           4'hF,    Z,            16'd0, 16'd0};
        vt[4]  = '{O, I, O, O, 32'h9999_0000, Z,            4'hF,    O, Z,             I, I, O, O, 32'h0000_1234, Z,           4'hF,    Z,            16'd0, 16'd0};
        vt[5]  = '{O, I, O, O, 32'h9999_0000, Z,            4'hF,    I, 32'hDEAD_BEEF, I, I, O, O, 32'h0000_1234, Z,           4'hF,    Z,            16'd0, 16'd0};
        vt[6]  = '{O, I, O, O, 32'h9999_0000, Z,            4'hF,    I, Z,             I, O, O, I, Z,            Z,            4'h0,    32'hDEAD_BEEF, 16'd1, 16'd0};
        vt[7]  = '{O, I, O, I, 32'h0000_1234, Z,            4'hF,    O, Z,             O, O, O, O, Z,            Z,            4'h0,    32'hDEAD_BEEF, 16'd1, 16'd0};
        vt[8]  = '{O, I, I, O, 32'h0000_2002, 32'hA5A5_A5A5, 4'b0011, O, Z,            I, O, O, O, Z,            Z,            4'h0,    32'hDEAD_BEEF, 16'd1, 16'd0};
        vt[9]  = '{O, I, I, O, 32'h0000_2002, 32'hA5A5_A5A5, 4'b0011, I, Z,            O, I, I, O, 32'h0000_2000, 32'hA5A5_A5A5, 4'b0011, 32'hDEAD_BEEF, 16'd1, 16'd0};
        vt[10] = '{O, O, O, O, Z,             Z,            4'h0,    O, Z,             O, O, O, O, Z,            Z,            4'h0,    32'hDEAD_BEEF, 16'd1, 16'd1};
        vt[11] = '{I, O, O, O, Z,             Z,            4'h0,    O, Z,             O, O, O, O, Z,            Z,            4'h0,    Z,            16'd0, 16'd0};
        vt[12] = '{O, I, O, O, 32'h0000_3000, Z,            4'hF,    O, Z,             I, O, O, O, Z,            Z,            4'h0,    Z,            16'd0, 16'd0};
        vt[13] = '{O, I, O, O, 32'h0000_4444, Z,            4'hF,    I, 32'h1111_2222, I, I, O, O, 32'h0000_3000, Z,           4'hF,    Z,            16'd0, 16'd0};
        vt[14] = '{O, I, O, I, 32'h0000_3000, Z,            4'hF,    O, Z,             I, O, O, I, Z,            Z,            4'h0,    32'h1111_2222, 16'd1, 16'd0};
        vt[15] = '{O, I, I, O, 32'h0000_5000, 32'h0BAD_F00D, 4'hF,   O, Z,             I, O, O, O, Z,            Z,            4'h0,    32'h1111_2222, 16'd1, 16'd0};
        vt[16] = '{O, I, I, O, 32'h0000_6000, 32'h7777_7777, 4'h1,   O, Z,             I, I, I, O, 32'h0000_5000, 32'h0BAD_F00D, 4'hF,  32'h1111_2222, 16'd1, 16'd0};
        vt[17] = '{O, I, I, O, 32'h0000_6000, 32'h7777_7777, 4'h1,   I, Z,             O, I, I, O, 32'h0000_5000, 32'h0BAD_F00D, 4'hF,  32'h1111_2222, 16'd1, 16'd0};
        vt[18] = '{O, O, O, O, Z,             Z,            4'h0,    O, Z,             O, O, O, O, Z,            Z,            4'h0,    32'h1111_2222, 16'd1, 16'd1};

        drive(I, O, O, O, Z, Z, 4'h0, O, Z);
        tick();
        tick();

        for (int i = 0; i < 19; i++) begin
            apply(i);
        end

        // Reset while a read is outstanding, with the ack arriving during reset.
        drive(O, I, O, O, 32'h0000_7000, Z, 4'hF, O, Z);
        #2;
        chk("abort detect stall", 32'(stall), 32'(I));
        tick();
        drive(O, O, O, O, Z, Z, 4'h0, O, Z);
        #2;
        chk("abort rd_req mem_req", 32'(mem_req), 32'(I));
        chk("abort rd_req mem_addr", mem_addr, 32'h0000_7000);
        tick();
        drive(I, O, O, O, Z, Z, 4'h0, I, 32'hCAFE_F00D);
        #2;
        chk("abort rst stall", 32'(stall), 32'(O));
        chk("abort rst mem_req", 32'(mem_req), 32'(O));
        chk("abort rst mem_addr", mem_addr, Z);
        chk("abort rst mem_be", 32'(mem_be), Z);
        chk("abort rst fill_en", 32'(fill_en), 32'(O));
        chk("abort rst fill_data", fill_data, Z);
        chk("abort rst rd_cnt", 32'(rd_cnt), Z);
        chk("abort rst wr_cnt", 32'(wr_cnt), Z);
        tick();
        drive(O, O, O, O, Z, Z, 4'h0, I, 32'hCAFE_F00D);
        #2;
        chk("abort post stall", 32'(stall), 32'(O));
        chk("abort post mem_req", 32'(mem_req), 32'(O));
        chk("abort post fill_en", 32'(fill_en), 32'(O));
        chk("abort post fill_data", fill_data, Z);
        chk("abort post rd_cnt", 32'(rd_cnt), Z);
        tick();
        drive(O, I, O, I, 32'h0000_8000, Z, 4'hF, O, Z);
        #2;
        chk("abort idle hit stall", 32'(stall), 32'(O));
        chk("abort idle fill_en", 32'(fill_en), 32'(O));
        tick();

        // Five read misses since reset: wide counter reaches 5, 2-bit counter holds at 3.
        for (int k = 1; k <= 5; k++) begin
            do_miss(32'h0000_8000 + 32'(k * 4), 32'h1234_5670 + 32'(k));
            drive(O, O, O, O, Z, Z, 4'h0, O, Z);
            #2;
            chk($sformatf("sat%0d rd_cnt", k), 32'(rd_cnt), 32'(k));
            chk($sformatf("sat%0d narrow rd_cnt", k), 32'(s_rd_cnt), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("sat%0d fill_data", k), fill_data, 32'h1234_5670 + 32'(k));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
